// File: rtl/udp_tx_packetizer.sv
// Cuts a continuous 32-bit AXI-Stream into UDP payload packets closed on tlast, MAX_WORDS or idle
// timeout. Build macro UDP_PKT_TIMEOUT_EN enables the idle timer; without it held words wait forever.
module udp_tx_packetizer #(
    parameter int unsigned MAX_WORDS   = 368,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [15:0] pkt_count,
    output logic        timeout_flush
);

    localparam logic [15:0] WLast = 16'(MAX_WORDS - 1);

    logic        hold_v_q, hold_v_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        hold_fin_q, hold_fin_d;
    logic        out_v_q, out_v_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [15:0] pkt_q, pkt_d;

    logic        out_free;
    logic        accept;
    logic        xfer;
    logic        timeout_evt;
    logic        to_close;
    logic        fin_in;
    logic [15:0] wcnt_eff;

    assign out_free = !out_v_q || m_axis_tready;
    assign accept   = s_axis_tvalid && s_axis_tready;
    assign xfer     = hold_v_q && out_free && (hold_fin_q || accept || timeout_evt);

`ifdef UDP_PKT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] timer_q, timer_d;
    logic          to_latch_q, to_latch_d;
    logic          flush_q, flush_d;

    // Timer saturates at the timeout value so a stalled output keeps the close request alive.
    assign timeout_evt = hold_v_q && !hold_fin_q && (timer_q == TW'(TIMEOUT_CYC - 1));
    assign to_close    = hold_v_q && !hold_fin_q && (to_latch_q || (timeout_evt && !accept));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            timer_q    <= '0;
            to_latch_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            to_latch_q <= to_latch_d;
            flush_q    <= flush_d;
        end
    end

    always_comb begin
        timer_d    = timer_q;
        to_latch_d = to_latch_q;
        flush_d    = xfer && to_close;
        if (accept || xfer) begin
            timer_d = '0;
        end else if (hold_v_q && !hold_fin_q && !timeout_evt) begin
            timer_d = timer_q + TW'(1);
        end
        if (xfer) begin
            to_latch_d = 1'b0;
        end else if (timeout_evt) begin
            to_latch_d = 1'b1;
        end
    end

    assign timeout_flush = flush_q;
`else
    assign timeout_evt   = 1'b0;
    assign to_close      = 1'b0;
    assign timeout_flush = 1'b0;
`endif

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hold_v_q    <= 1'b0;
            hold_data_q <= '0;
            hold_fin_q  <= 1'b0;
            out_v_q     <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            wcnt_q      <= '0;
            pkt_q       <= '0;
        end else begin
            hold_v_q    <= hold_v_d;
            hold_data_q <= hold_data_d;
            hold_fin_q  <= hold_fin_d;
            out_v_q     <= out_v_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            wcnt_q      <= wcnt_d;
            pkt_q       <= pkt_d;
        end
    end

    // Next-state logic
    always_comb begin
        hold_v_d    = hold_v_q;
        hold_data_d = hold_data_q;
        hold_fin_d  = hold_fin_q;
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        wcnt_d      = wcnt_q;
        pkt_d       = pkt_q;

        // A word accepted alongside a timeout close starts a fresh packet.
        wcnt_eff = (xfer && to_close) ? 16'd0 : wcnt_q;
        fin_in   = s_axis_tlast || (wcnt_eff == WLast);

        if (accept) begin
            hold_v_d    = 1'b1;
            hold_data_d = s_axis_tdata;
            hold_fin_d  = fin_in;
            wcnt_d      = fin_in ? 16'd0 : wcnt_eff + 16'd1;
        end else begin
            if (xfer) begin
                hold_v_d = 1'b0;
            end
            wcnt_d = wcnt_eff;
        end

        if (xfer) begin
            out_v_d    = 1'b1;
            out_data_d = hold_data_q;
            out_last_d = hold_fin_q || to_close;
        end else if (m_axis_tready) begin
            out_v_d = 1'b0;
        end

        if (out_v_q && m_axis_tready && out_last_q) begin
            pkt_d = pkt_q + 16'd1;
        end
    end

    // Outputs
    assign s_axis_tready = !areset && (!hold_v_q || out_free);
    assign m_axis_tvalid = out_v_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
    assign pkt_count     = pkt_q;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Bench for udp_tx_packetizer: directed scenarios plus randomized traffic, checked against a
// word-level packet model built from accept times (timeout = no new word within TIMEOUT_CYC cycles).
module tb_udp_tx_packetizer;

    localparam int unsigned MAXW = 4;
    localparam int unsigned TCYC = 8;
`ifdef UDP_PKT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [15:0] pkt_count;
    logic        timeout_flush;

    always #5 aclk = ~aclk;

    udp_tx_packetizer #(
        .MAX_WORDS  (MAXW),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast (m_tlast),
        .m_axis_tready(m_tready),
        .pkt_count    (pkt_count),
        .timeout_flush(timeout_flush)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    bit          have_pend = 1'b0;
    logic [31:0] pend_d;
    int          pend_c;
    int          wc = 0;
    int          exp_pkts = 0;
    int          exp_flush = 0;
    int          flush_seen = 0;
    bit          rnd_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic        prev_l;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void push_exp(input logic [31:0] d, input bit last);
        exp_q.push_back({last, d});
        if (last) exp_pkts++;
    endfunction

    // Packet model: a non-final word is closed by timeout if the next word arrives more than
    // TCYC cycles after it; otherwise the packet continues.
    function automatic void model_accept(input logic [31:0] d, input logic l, input int c);
        bit closed;
        if (have_pend) begin
            closed = TO_EN && ((c - pend_c) > int'(TCYC));
            push_exp(pend_d, closed);
            if (closed) begin
                exp_flush++;
                wc = 0;
            end
            have_pend = 1'b0;
        end
        if (l || wc == int'(MAXW) - 1) begin
            push_exp(d, 1'b1);
            wc = 0;
        end else begin
            wc++;
            pend_d    = d;
            pend_c    = c;
            have_pend = 1'b1;
        end
    endfunction

    always @(posedge aclk) cyc++;

    always @(posedge aclk) begin
        if (rnd_ready) begin
            #1;
            m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: inputs settle 1 time unit after posedge, so negedge sees what the next edge takes.
    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("axis_valid_hold", 64'(m_tvalid), 64'd1);
                check_eq("axis_data_hold", 64'({m_tlast, m_tdata}), 64'({prev_l, prev_d}));
            end
            if (s_tvalid && s_tready) model_accept(s_tdata, s_tlast, cyc + 1);
            if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
            if (timeout_flush) flush_seen++;
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bit done = 1'b0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            if (s_tready) done = 1'b1;
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check_eq("send_accepted", 64'(done), 64'd1);
    endtask

    task automatic finish_phase(input string tag);
        int n;
        rnd_ready = 1'b0;
        @(posedge aclk);
        #2;
        m_tready = 1'b1;
        idle(20);
        if (TO_EN && have_pend) begin
            push_exp(pend_d, 1'b1);
            exp_flush++;
            wc        = 0;
            have_pend = 1'b0;
        end
        check_eq({tag, "_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_word"}, 64'(obs_q[i]), 64'(exp_q[i]));
        end
        check_eq({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkts[15:0]));
        check_eq({tag, "_flush"}, 64'(flush_seen), 64'(exp_flush));
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int f0;
        int n;
        bit seen;

        areset   = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        idle(3);
        check_eq("rst_out", 64'({m_tvalid, m_tlast, m_tdata}), 64'd0);
        check_eq("rst_s_ready", 64'(s_tready), 64'd0);
        check_eq("rst_pkt_count", 64'(pkt_count), 64'd0);
        check_eq("rst_flush", 64'(timeout_flush), 64'd0);
        areset   = 1'b0;
        m_tready = 1'b1;
        idle(2);

        // 1: back-to-back stream, closed by word count
        for (int i = 1; i <= 8; i++) send(32'(i), 1'b0);
        finish_phase("t1");
        check_eq("t1_two_pkts", 64'(pkt_count), 64'd2);

        // 2: two words then idle
        f0 = flush_seen;
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            @(posedge aclk);
            #1;
            n++;
            if (m_tvalid && m_tdata == 32'hB) seen = 1'b1;
        end
        check_eq("t2_b_emitted", 64'(seen), 64'(TO_EN));
`ifdef UDP_PKT_TIMEOUT_EN
        check_eq("t2_b_latency", 64'(n), 64'd8);
        check_eq("t2_b_tlast", 64'(m_tlast), 64'd1);
        finish_phase("t2");
        check_eq("t2_one_flush", 64'(flush_seen - f0), 64'd1);
`else
        check_eq("t2_b_held", 64'(m_tvalid), 64'd0);
        finish_phase("t2");
        check_eq("t2_no_flush", 64'(flush_seen - f0), 64'd0);
`endif

        // 3: user tlast
        f0 = flush_seen;
        send(32'h1, 1'b0);
        send(32'h2, 1'b1);
        @(posedge aclk);
        #1;
        check_eq("t3_tlast_word", 64'({m_tvalid, m_tlast, m_tdata}), {31'd0, 1'b1, 1'b1, 32'h2});
        finish_phase("t3");
        check_eq("t3_no_flush", 64'(flush_seen - f0), 64'd0);

        // 4: output stall mid-stream
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'h40 + 32'(i), 1'b0);
            end
            begin
                m_tready = 1'b0;
                idle(10);
                check_eq("t4_s_ready_low", 64'(s_tready), 64'd0);
                idle(10);
                m_tready = 1'b1;
            end
        join
        finish_phase("t4");

        // 5: next word lands exactly in the timeout cycle
        f0 = flush_seen;
        send(32'h50, 1'b0);
        idle(int'(TCYC) - 1);
        send(32'h51, 1'b0);
        send(32'h52, 1'b0);
        send(32'h53, 1'b0);
        finish_phase("t5");
        check_eq("t5_no_flush", 64'(flush_seen - f0), 64'd0);

        // 6: asynchronous reset with words inside
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_tdata = 32'h60 + 32'(i);
            idle(1);
        end
        s_tvalid = 1'b0;
        check_eq("t6_pre_valid", 64'(m_tvalid), 64'd1);
        check_eq("t6_pre_nothing_out", 64'(obs_q.size()), 64'd0);
        @(negedge aclk);
        #2;
        areset = 1'b1;
        #1;
        check_eq("t6_async_out", 64'({m_tvalid, m_tlast, m_tdata}), 64'd0);
        check_eq("t6_async_s_ready", 64'(s_tready), 64'd0);
        check_eq("t6_async_pkt_count", 64'(pkt_count), 64'd0);
        check_eq("t6_async_flush", 64'(timeout_flush), 64'd0);
        exp_q.delete();
        obs_q.delete();
        have_pend  = 1'b0;
        wc         = 0;
        exp_pkts   = 0;
        exp_flush  = 0;
        flush_seen = 0;
        idle(2);
        areset   = 1'b0;
        m_tready = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) send(32'h70 + 32'(i), 1'b0);
        finish_phase("t6");
        check_eq("t6_one_pkt", 64'(pkt_count), 64'd1);

        // Randomized traffic with random gaps, tlast and backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            idle($urandom_range(0, 11));
            send($urandom, ($urandom_range(0, 7) == 0));
        end
        finish_phase("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
